// File: rtl/control_sequencer.sv
// Microcoded T-state sequencer for the 16-bit SAP computer: fetch/execute strobes, carry/zero flags, halt.
// Optional macro CTRL_COND_JUMP_EN enables JC/JZ; when undefined, opcodes 7 and 8 decode as NOP.
module control_sequencer #(
  parameter int unsigned LAST_T = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       alu_carry,
  input  logic       alu_zero,
  output logic       pc_oe,
  output logic       pc_inc,
  output logic       pc_write,
  output logic       mar_we,
  output logic       mem_oe,
  output logic       mem_we,
  output logic       ir_we,
  output logic       ir_oe,
  output logic       a_we,
  output logic       a_oe,
  output logic       b_we,
  output logic       alu_oe,
  output logic       alu_sub,
  output logic       out_we,
  output logic       carry_flag,
  output logic       zero_flag,
  output logic [2:0] t_state,
  output logic       halted
);

  localparam int unsigned TW = 3;

  localparam logic [3:0] OP_LDA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_STA = 4'd4;
  localparam logic [3:0] OP_LDI = 4'd5;
  localparam logic [3:0] OP_JMP = 4'd6;
  localparam logic [3:0] OP_JC  = 4'd7;
  localparam logic [3:0] OP_JZ  = 4'd8;
  localparam logic [3:0] OP_OUT = 4'd14;
  localparam logic [3:0] OP_HLT = 4'd15;

  typedef enum logic [TW-1:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } tstate_e;

  tstate_e       t_q, t_d;
  logic          halt_q, halt_d;
  logic          carry_q, carry_d;
  logic          zero_q, zero_d;
  logic [TW-1:0] last_c;

  // Final T-state of the current instruction; only meaningful from T2 on.
  always_comb begin
    last_c = TW'(2);
    case (opcode)
      OP_LDA, OP_STA: last_c = TW'(3);
      OP_ADD, OP_SUB: last_c = TW'(LAST_T);
      default:        last_c = TW'(2);
    endcase
  end

  // Next-state: advance, wrap early at the last step, or park in T2 on halt.
  always_comb begin
    t_d     = t_q;
    halt_d  = halt_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    if (!halt_q) begin
      if (t_q == T2 && opcode == OP_HLT) begin
        halt_d = 1'b1;
      end else if (t_q >= T2 && t_q == last_c) begin
        t_d = T0;
      end else begin
        t_d = tstate_e'(t_q + TW'(1));
      end
      if (t_q == T4 && (opcode == OP_ADD || opcode == OP_SUB)) begin
        carry_d = alu_carry;
        zero_d  = alu_zero;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_q     <= T0;
      halt_q  <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      t_q     <= t_d;
      halt_q  <= halt_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  // Strobe decode; everything stays low while halted.
  always_comb begin
    pc_oe    = 1'b0;
    pc_inc   = 1'b0;
    pc_write = 1'b0;
    mar_we   = 1'b0;
    mem_oe   = 1'b0;
    mem_we   = 1'b0;
    ir_we    = 1'b0;
    ir_oe    = 1'b0;
    a_we     = 1'b0;
    a_oe     = 1'b0;
    b_we     = 1'b0;
    alu_oe   = 1'b0;
    alu_sub  = 1'b0;
    out_we   = 1'b0;
    if (!halt_q) begin
      case (t_q)
        T0: begin
          pc_oe  = 1'b1;
          mar_we = 1'b1;
        end
        T1: begin
          mem_oe = 1'b1;
          ir_we  = 1'b1;
          pc_inc = 1'b1;
        end
        T2: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ir_oe  = 1'b1;
              mar_we = 1'b1;
            end
            OP_LDI: begin
              ir_oe = 1'b1;
              a_we  = 1'b1;
            end
            OP_JMP: begin
              ir_oe    = 1'b1;
              pc_write = 1'b1;
            end
`ifdef CTRL_COND_JUMP_EN
            OP_JC: begin
              ir_oe    = carry_q;
              pc_write = carry_q;
            end
            OP_JZ: begin
              ir_oe    = zero_q;
              pc_write = zero_q;
            end
`endif
            OP_OUT: begin
              a_oe   = 1'b1;
              out_we = 1'b1;
            end
            default: ;
          endcase
        end
        T3: begin
          case (opcode)
            OP_LDA: begin
              mem_oe = 1'b1;
              a_we   = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              mem_oe = 1'b1;
              b_we   = 1'b1;
            end
            OP_STA: begin
              a_oe   = 1'b1;
              mem_we = 1'b1;
            end
            default: ;
          endcase
        end
        T4: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            alu_oe  = 1'b1;
            a_we    = 1'b1;
            alu_sub = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign carry_flag = carry_q;
  assign zero_flag  = zero_q;
  assign t_state    = t_q;
  assign halted     = halt_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed testbench for control_sequencer: hand-computed strobe masks per T-state.
module tb_control_sequencer;

  logic       clk, rst;
  logic [3:0] opcode;
  logic       alu_carry, alu_zero;
  logic       pc_oe, pc_inc, pc_write, mar_we, mem_oe, mem_we, ir_we, ir_oe;
  logic       a_we, a_oe, b_we, alu_oe, alu_sub, out_we;
  logic       carry_flag, zero_flag, halted;
  logic [2:0] t_state;

  int total = 0;
  int bad   = 0;

  localparam logic [13:0] PC_OE   = 14'h2000;
  localparam logic [13:0] PC_INC  = 14'h1000;
  localparam logic [13:0] PC_WR   = 14'h0800;
  localparam logic [13:0] MAR_WE  = 14'h0400;
  localparam logic [13:0] MEM_OE  = 14'h0200;
  localparam logic [13:0] MEM_WE  = 14'h0100;
  localparam logic [13:0] IR_WE   = 14'h0080;
  localparam logic [13:0] IR_OE   = 14'h0040;
  localparam logic [13:0] A_WE    = 14'h0020;
  localparam logic [13:0] A_OE    = 14'h0010;
  localparam logic [13:0] B_WE    = 14'h0008;
  localparam logic [13:0] ALU_OE  = 14'h0004;
  localparam logic [13:0] ALU_SUB = 14'h0002;
  localparam logic [13:0] OUT_WE  = 14'h0001;
  localparam logic [13:0] S_T0    = PC_OE | MAR_WE;
  localparam logic [13:0] S_T1    = MEM_OE | IR_WE | PC_INC;

`ifdef CTRL_COND_JUMP_EN
  localparam logic [13:0] S_CJ = IR_OE | PC_WR;
`else
  localparam logic [13:0] S_CJ = 14'h0000;
`endif

  logic [13:0] strobes;
  logic [4:0]  oes;
  assign strobes = {pc_oe, pc_inc, pc_write, mar_we, mem_oe, mem_we, ir_we, ir_oe,
                    a_we, a_oe, b_we, alu_oe, alu_sub, out_we};
  assign oes = {pc_oe, mem_oe, ir_oe, a_oe, alu_oe};

  control_sequencer dut (
    .clk(clk), .rst(rst), .opcode(opcode), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .pc_oe(pc_oe), .pc_inc(pc_inc), .pc_write(pc_write), .mar_we(mar_we),
    .mem_oe(mem_oe), .mem_we(mem_we), .ir_we(ir_we), .ir_oe(ir_oe),
    .a_we(a_we), .a_oe(a_oe), .b_we(b_we), .alu_oe(alu_oe), .alu_sub(alu_sub),
    .out_we(out_we), .carry_flag(carry_flag), .zero_flag(zero_flag),
    .t_state(t_state), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_s(input string tag, input logic [13:0] exp_s, input int exp_t);
    chk({tag, "_strobes"}, 32'(strobes), 32'(exp_s));
    chk({tag, "_t"}, 32'(t_state), 32'(exp_t));
  endtask

  task automatic chk_flags(input string tag, input logic c, input logic z);
    chk({tag, "_flags"}, 32'({carry_flag, zero_flag}), 32'({c, z}));
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Run from T1 with the next opcode loaded; strobe masks for T2.. given in order.
  task automatic run_instr(input string tag, input logic [3:0] op, input int n,
                           input logic [13:0] s2, input logic [13:0] s3, input logic [13:0] s4);
    opcode = op;
    tick(); chk_s({tag, "_T2"}, s2, 2);
    if (n >= 4) begin tick(); chk_s({tag, "_T3"}, s3, 3); end
    if (n >= 5) begin tick(); chk_s({tag, "_T4"}, s4, 4); end
    tick(); chk_s({tag, "_T0"}, S_T0, 0);
    tick(); chk_s({tag, "_T1"}, S_T1, 1);
  endtask

  int exp_len [16] = '{3, 4, 5, 5, 4, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3};

  initial begin
    rst = 1'b1; opcode = 4'd0; alu_carry = 1'b0; alu_zero = 1'b0;
    #3;
    chk_s("reset", S_T0, 0);
    chk("reset_halted", 32'(halted), 32'd0);
    chk_flags("reset", 1'b0, 1'b0);
    #9 rst = 1'b0;
    tick(); chk_s("first_fetch", S_T1, 1);

    // ADD with carry=1 zero=0: flags change only after T4
    alu_carry = 1'b1; alu_zero = 1'b0;
    opcode = 4'd2;
    tick(); chk_s("add_T2", IR_OE | MAR_WE, 2);
    tick(); chk_s("add_T3", MEM_OE | B_WE, 3);
    tick(); chk_s("add_T4", ALU_OE | A_WE, 4); chk_flags("add_T4", 1'b0, 1'b0);
    tick(); chk_s("add_T0", S_T0, 0); chk_flags("add_done", 1'b1, 1'b0);
    alu_carry = 1'b0; alu_zero = 1'b1;
    tick(); chk_s("add_T1", S_T1, 1);

    run_instr("jc_taken", 4'd7, 3, S_CJ, '0, '0);
    chk_flags("jc_hold", 1'b1, 1'b0);
    run_instr("sub", 4'd3, 5, IR_OE | MAR_WE, MEM_OE | B_WE, ALU_OE | A_WE | ALU_SUB);
    chk_flags("sub_done", 1'b0, 1'b1);
    run_instr("jc_not", 4'd7, 3, 14'h0000, '0, '0);
    run_instr("jz_taken", 4'd8, 3, S_CJ, '0, '0);
    run_instr("lda", 4'd1, 4, IR_OE | MAR_WE, MEM_OE | A_WE, '0);
    run_instr("ldi", 4'd5, 3, IR_OE | A_WE, '0, '0);
    run_instr("jmp", 4'd6, 3, IR_OE | PC_WR, '0, '0);
    run_instr("out", 4'd14, 3, A_OE | OUT_WE, '0, '0);
    run_instr("nop", 4'd0, 3, 14'h0000, '0, '0);
    run_instr("undef", 4'd10, 3, 14'h0000, '0, '0);
    chk_flags("flags_held", 1'b0, 1'b1);

    // STA interrupted by reset in T3
    opcode = 4'd4;
    tick(); chk_s("sta_T2", IR_OE | MAR_WE, 2);
    tick(); chk_s("sta_T3", A_OE | MEM_WE, 3);
    rst = 1'b1;
    #1;
    chk_s("sta_rst", S_T0, 0);
    chk_flags("sta_rst", 1'b0, 1'b0);
    @(negedge clk) rst = 1'b0;
    tick(); chk_s("post_rst", S_T1, 1);

    // HLT parks in T2 until reset
    opcode = 4'd15;
    tick(); chk_s("hlt_T2", 14'h0000, 2); chk("hlt_T2_halted", 32'(halted), 32'd0);
    for (int i = 0; i < 22; i++) begin
      tick();
      chk_s("halt", 14'h0000, 2);
      chk("halt_halted", 32'(halted), 32'd1);
    end
    rst = 1'b1;
    #1;
    chk_s("halt_rst", S_T0, 0);
    chk("halt_rst_halted", 32'(halted), 32'd0);
    @(negedge clk) rst = 1'b0;
    tick(); chk_s("sweep_start", S_T1, 1);

    // Opcode sweep: bus-contention invariants and instruction length
    alu_carry = 1'b1; alu_zero = 1'b1;
    for (int op = 0; op < 15; op++) begin
      int n;
      opcode = 4'(op);
      n = 2;
      for (int k = 0; k < 8; k++) begin
        tick();
        chk("oe_onehot0", 32'($countones(oes) <= 1), 32'd1);
        chk("inc_wr_excl", 32'(pc_inc & pc_write), 32'd0);
        if (t_state == 3'd0) break;
        n++;
      end
      chk($sformatf("len_op%0d", op), 32'(n), 32'(exp_len[op]));
      tick();
      chk("oe_onehot0", 32'($countones(oes) <= 1), 32'd1);
      chk("inc_wr_excl", 32'(pc_inc & pc_write), 32'd0);
    end
    chk_flags("sweep_flags", 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
